// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback stage: FLAGS bit layout,
// reserved-bit forcing pattern and the writeback FSM state encoding.
package alu_wb_pkg;

   localparam int FLAG_CF = 0;
   localparam int FLAG_PF = 2;
   localparam int FLAG_AF = 4;
   localparam int FLAG_ZF = 6;
   localparam int FLAG_SF = 7;
   localparam int FLAG_TF = 8;
   localparam int FLAG_IF = 9;
   localparam int FLAG_DF = 10;
   localparam int FLAG_OF = 11;

   // Bits 15:12, 5, 3, 1 are architecturally fixed; the value pins 15:12 and 1 high.
   localparam logic [15:0] FLAGS_RSV_MASK = 16'hF02A;
   localparam logic [15:0] FLAGS_RSV_VAL  = 16'hF002;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR_LO = 2'd1,
      ST_WR_HI = 2'd2,
      ST_EXC   = 2'd3
   } wb_state_t;

endpackage

// File: rtl/alu_wb_flags.sv
// Combinational merge of the 9-bit ALU flag vector into the 16-bit FLAGS
// image with reserved bits forced; shared with the POPF path.
module alu_wb_flags
   import alu_wb_pkg::*;
(
   input  logic [8:0]  oflags,
   output logic [15:0] flags
);

   logic [15:0] raw;

   always_comb begin
      raw          = '0;
      raw[FLAG_CF] = oflags[0];
      raw[FLAG_PF] = oflags[1];
      raw[FLAG_AF] = oflags[2];
      raw[FLAG_ZF] = oflags[3];
      raw[FLAG_SF] = oflags[4];
      raw[FLAG_TF] = oflags[5];
      raw[FLAG_IF] = oflags[6];
      raw[FLAG_DF] = oflags[7];
      raw[FLAG_OF] = oflags[8];
      flags        = (raw & ~FLAGS_RSV_MASK) | FLAGS_RSV_VAL;
   end

endmodule

// File: rtl/alu_wb.sv
// ALU writeback stage: registers ALU results into register-file writes
// (two beats for 32-bit results), merges FLAGS, turns divide faults into IRQs.
module alu_wb
   import alu_wb_pkg::*;
#(
   parameter logic [3:0]  DX_ADDR   = 4'd2,
   parameter logic [7:0]  DIV_VEC   = 8'd0,
   parameter logic [15:0] FLAGS_RST = 16'hF002
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic [31:0] alu_out,
   input  logic [8:0]  alu_oflags,
   input  logic        div_exc,
   input  logic        word_op,
   input  logic        wide,
   input  logic [3:0]  dst,
   input  logic        rf_we_en,
   input  logic        fl_we_en,
   output logic        rf_we,
   output logic [3:0]  rf_addr,
   output logic [15:0] rf_data,
   output logic        rf_byte,
   output logic [15:0] flags,
   output logic        int_req,
   output logic [7:0]  int_vec,
   input  logic        int_ack
);

   // state    | meaning
   // ST_IDLE  | ready for a new ALU result
   // ST_WR_LO | low-word write on the rf port, FLAGS commit at end of cycle
   // ST_WR_HI | high-word write of a wide result into DX
   // ST_EXC   | divide fault pending, int_req held until int_ack

   wb_state_t   state;
   logic [15:0] out_hi_q;
   logic [8:0]  oflags_q;
   logic        fl_we_en_q;
   logic        wide_q;
   logic [15:0] flags_merged;

   alu_wb_flags u_flags (
      .oflags (oflags_q),
      .flags  (flags_merged)
   );

   assign ready_out = (state == ST_IDLE);

   // The low-word write fields are loaded straight from the inputs on accept
   // so they are already on the rf port during ST_WR_LO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         rf_we      <= 1'b0;
         rf_addr    <= '0;
         rf_data    <= '0;
         rf_byte    <= 1'b0;
         flags      <= FLAGS_RST;
         int_req    <= 1'b0;
         int_vec    <= '0;
         out_hi_q   <= '0;
         oflags_q   <= '0;
         fl_we_en_q <= 1'b0;
         wide_q     <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_in) begin
                  if (div_exc) begin
                     state   <= ST_EXC;
                     int_req <= 1'b1;
                     int_vec <= DIV_VEC;
                  end else begin
                     state      <= ST_WR_LO;
                     rf_we      <= rf_we_en;
                     rf_addr    <= dst;
                     rf_data    <= alu_out[15:0];
                     rf_byte    <= ~word_op;
                     out_hi_q   <= alu_out[31:16];
                     oflags_q   <= alu_oflags;
                     fl_we_en_q <= fl_we_en;
                     wide_q     <= wide;
                  end
               end
            end
            ST_WR_LO: begin
               if (fl_we_en_q) begin
                  flags <= flags_merged;
               end
               if (wide_q) begin
                  state   <= ST_WR_HI;
                  rf_we   <= 1'b1;
                  rf_addr <= DX_ADDR;
                  rf_data <= out_hi_q;
                  rf_byte <= 1'b0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WR_HI: begin
               state <= ST_IDLE;
            end
            ST_EXC: begin
               if (int_ack) begin
                  int_req <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_wb.sv
// Self-checking bench for alu_wb: event-queue reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [31:0] alu_out = '0;
   logic [8:0]  alu_oflags = '0;
   logic        div_exc = 1'b0;
   logic        word_op = 1'b0;
   logic        wide = 1'b0;
   logic [3:0]  dst = '0;
   logic        rf_we_en = 1'b0;
   logic        fl_we_en = 1'b0;
   logic        rf_we;
   logic [3:0]  rf_addr;
   logic [15:0] rf_data;
   logic        rf_byte;
   logic [15:0] flags;
   logic        int_req;
   logic [7:0]  int_vec;
   logic        int_ack = 1'b0;

   always #5 clk = ~clk;

   alu_wb dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .alu_out    (alu_out),
      .alu_oflags (alu_oflags),
      .div_exc    (div_exc),
      .word_op    (word_op),
      .wide       (wide),
      .dst        (dst),
      .rf_we_en   (rf_we_en),
      .fl_we_en   (fl_we_en),
      .rf_we      (rf_we),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .rf_byte    (rf_byte),
      .flags      (flags),
      .int_req    (int_req),
      .int_vec    (int_vec),
      .int_ack    (int_ack)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          t;
      logic [3:0]  a;
      logic [15:0] d;
      logic        b;
   } wr_t;
   typedef struct {
      int          t;
      logic [15:0] v;
   } fl_t;

   wr_t         wq[$];
   fl_t         fq[$];
   int          cyc;
   int          free_at;
   bit          in_exc;
   logic [15:0] flags_m;
   logic [7:0]  vec_m;
   bit          exp_we;
   logic [3:0]  exp_a;
   logic [15:0] exp_d;
   logic        exp_b;
   bit          chk_en = 0;

   function automatic logic [15:0] merge(input logic [8:0] of);
      int          pos [0:8] = '{0, 2, 4, 6, 7, 8, 9, 10, 11};
      logic [15:0] f = 16'hF002;
      for (int i = 0; i < 9; i++)
         if (of[i]) f[pos[i]] = 1'b1;
      return f;
   endfunction

   // Accept at end of cycle c: low write visible in c+1, high write in c+2,
   // new FLAGS from c+2, stage free again at c+2 (narrow) or c+3 (wide).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wq.delete();
         fq.delete();
         cyc     = 0;
         free_at = 0;
         in_exc  = 0;
         flags_m = 16'hF002;
         vec_m   = 8'h00;
         exp_we  = 0;
         exp_a   = '0;
         exp_d   = '0;
         exp_b   = 1'b0;
      end else begin
         if (in_exc) begin
            if (int_ack) begin
               in_exc  = 0;
               free_at = cyc + 1;
            end
         end else if (valid_in && cyc >= free_at) begin
            if (div_exc) begin
               in_exc = 1;
               vec_m  = 8'h00;
            end else begin
               if (rf_we_en) wq.push_back(wr_t'{cyc + 1, dst, alu_out[15:0], ~word_op});
               if (wide)     wq.push_back(wr_t'{cyc + 2, 4'd2, alu_out[31:16], 1'b0});
               if (fl_we_en) fq.push_back(fl_t'{cyc + 2, merge(alu_oflags)});
               free_at = cyc + (wide ? 3 : 2);
            end
         end
         cyc++;
         exp_we = 0;
         if (wq.size() > 0 && wq[0].t == cyc) begin
            exp_we = 1;
            exp_a  = wq[0].a;
            exp_d  = wq[0].d;
            exp_b  = wq[0].b;
            void'(wq.pop_front());
         end
         while (fq.size() > 0 && fq[0].t <= cyc) begin
            flags_m = fq[0].v;
            void'(fq.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("ready_out", ready_out, (!in_exc && cyc >= free_at));
         check("rf_we", rf_we, exp_we);
         if (exp_we) begin
            check("rf_addr", rf_addr, exp_a);
            check("rf_data", rf_data, exp_d);
            check("rf_byte", rf_byte, exp_b);
         end
         check("flags", flags, flags_m);
         check("int_req", int_req, in_exc);
         check("int_vec", int_vec, vec_m);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [31:0] a, input logic [8:0] of, input logic dx,
                        input logic wo, input logic wd, input logic [3:0] d,
                        input logic rwe, input logic fwe);
      bit acc = 0;
      int k = 0;
      alu_out    = a;
      alu_oflags = of;
      div_exc    = dx;
      word_op    = wo;
      wide       = wd;
      dst        = d;
      rf_we_en   = rwe;
      fl_we_en   = fwe;
      valid_in   = 1'b1;
      while (!acc && k < 40) begin
         acc = ready_out;
         step();
         k++;
      end
      valid_in = 1'b0;
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got no accept, expected accept within 40 cycles");
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      chk_en = 1;
      step();
      check("rst_ready", ready_out, 1'b1);
      check("rst_flags", flags, 16'hF002);

      // narrow word write
      issue(32'h0000_1234, 9'b0_0000_0101, 0, 1, 0, 4'd0, 1, 1);
      check("nw_we", rf_we, 1'b1);
      check("nw_addr", rf_addr, 4'd0);
      check("nw_data", rf_data, 16'h1234);
      check("nw_byte", rf_byte, 1'b0);
      check("nw_busy", ready_out, 1'b0);
      step();
      check("nw_flags", flags, 16'hF013);
      check("nw_ready", ready_out, 1'b1);

      // wide result
      issue(32'hABCD_1234, 9'h000, 0, 1, 1, 4'd0, 1, 0);
      check("wd_lo_data", rf_data, 16'h1234);
      check("wd_lo_addr", rf_addr, 4'd0);
      check("wd_lo_busy", ready_out, 1'b0);
      step();
      check("wd_hi_we", rf_we, 1'b1);
      check("wd_hi_data", rf_data, 16'hABCD);
      check("wd_hi_addr", rf_addr, 4'd2);
      check("wd_hi_busy", ready_out, 1'b0);
      step();
      check("wd_ready", ready_out, 1'b1);

      // divide exception
      issue(32'h0000_5555, 9'h1FF, 1, 1, 0, 4'd3, 1, 1);
      for (int i = 0; i < 5; i++) begin
         check("dv_req", int_req, 1'b1);
         check("dv_vec", int_vec, 8'h00);
         check("dv_nowe", rf_we, 1'b0);
         check("dv_flags", flags, 16'hF013);
         step();
      end
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      check("dv_ack_req", int_req, 1'b0);
      check("dv_ack_ready", ready_out, 1'b1);

      // byte write with all flags set
      issue(32'h0000_00FF, 9'h1FF, 0, 0, 0, 4'd4, 1, 1);
      check("bw_byte", rf_byte, 1'b1);
      check("bw_addr", rf_addr, 4'd4);
      check("bw_data", rf_data, 16'h00FF);
      step();
      check("bw_flags", flags, 16'hFFD7);

      // stall: second instruction offered while first is still writing
      issue(32'h1111_2222, 9'h000, 0, 1, 1, 4'd5, 1, 0);
      issue(32'h3333_4444, 9'h000, 0, 1, 0, 4'd6, 1, 0);
      check("st_data", rf_data, 16'h4444);
      check("st_addr", rf_addr, 4'd6);
      repeat (3) step();

      // asynchronous reset in the middle of a wide write
      issue(32'h7777_8888, 9'h0FF, 0, 1, 1, 4'd7, 1, 1);
      #1 rst = 1'b1;
      #1;
      check("ar_flags", flags, 16'hF002);
      check("ar_we", rf_we, 1'b0);
      check("ar_req", int_req, 1'b0);
      check("ar_ready", ready_out, 1'b1);
      step();
      rst = 1'b0;
      step();

      // asynchronous reset while an interrupt is pending
      issue(32'h0, 9'h0, 1, 1, 0, 4'd1, 1, 1);
      check("ex_req", int_req, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("ex_rst_req", int_req, 1'b0);
      check("ex_rst_ready", ready_out, 1'b1);
      step();
      rst = 1'b0;
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         valid_in   = 1'($urandom_range(0, 1));
         alu_out    = $urandom();
         alu_oflags = 9'($urandom());
         div_exc    = ($urandom_range(0, 7) == 0);
         word_op    = 1'($urandom_range(0, 1));
         wide       = 1'($urandom_range(0, 1));
         dst        = 4'($urandom());
         rf_we_en   = ($urandom_range(0, 3) != 0);
         fl_we_en   = 1'($urandom_range(0, 1));
         int_ack    = ($urandom_range(0, 3) == 0);
         step();
      end
      valid_in = 1'b0;
      int_ack  = 1'b0;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
